// File: rtl/la_pkg.sv
// Shared types and constants for the triggered logic-analyzer capture engine.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    DONE
  } la_state_t;

  localparam logic [1:0] TRIG_IMM    = 2'b00;
  localparam logic [1:0] TRIG_LEVEL  = 2'b01;
  localparam logic [1:0] TRIG_RISE   = 2'b10;
  localparam logic [1:0] TRIG_CHANGE = 2'b11;

endpackage

// File: rtl/la_trigger_match.sv
// Masked trigger comparator; keeps the previous probe sample for edge/change modes.
module la_trigger_match
  import la_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] probe_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] value,
  output logic             hit
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= probe_in;
    end
  end

  always_comb begin
    hit = 1'b0;
    case (mode)
      TRIG_IMM:    hit = 1'b1;
      TRIG_LEVEL:  hit = ((probe_in & mask) == (value & mask));
      TRIG_RISE:   hit = |(probe_in & ~prev & mask);
      TRIG_CHANGE: hit = |((probe_in ^ prev) & mask);
      default:     hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/la_trigger_capture.sv
// Triggered capture into a circular buffer with a programmable pre-trigger window;
// read-out is trigger-aligned so logical address 0 is the oldest kept sample.
module la_trigger_capture
  import la_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] probe_in,
  input  logic             arm,
  input  logic             abort,
  input  logic [1:0]       trig_mode,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [AW-1:0]    pretrig,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             armed,
  output logic             triggered,
  output logic             done
);

  la_state_t        state, state_next;
  logic [1:0]       mode_l;
  logic [WIDTH-1:0] mask_l, value_l;
  logic [AW-1:0]    pretrig_l;
  logic [AW-1:0]    wr_ptr, trig_ptr, cnt, rem, rem_init, rd_phys;
  logic             hit, capturing, trig_fire, arm_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  la_trigger_match #(.WIDTH(WIDTH)) u_match (
    .clk      (clk),
    .rst      (rst),
    .probe_in (probe_in),
    .mode     (mode_l),
    .mask     (mask_l),
    .value    (value_l),
    .hit      (hit)
  );

  assign capturing = (state == PRE) || (state == WAIT) || (state == POST);
  assign arm_ok    = arm && !abort && ((state == IDLE) || (state == DONE));
  assign trig_fire = (state == WAIT) && hit && !abort;
  // Samples still to take after the trigger sample itself.
  assign rem_init  = AW'(DEPTH - 1) - pretrig_l;

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) state_next = (pretrig != '0) ? PRE : WAIT;
        PRE:        if (cnt == pretrig_l - AW'(1)) state_next = WAIT;
        WAIT:       if (hit) state_next = (rem_init == '0) ? DONE : POST;
        POST:       if (rem == AW'(1)) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      cnt       <= '0;
      rem       <= '0;
      mode_l    <= TRIG_IMM;
      mask_l    <= '0;
      value_l   <= '0;
      pretrig_l <= '0;
    end else begin
      state <= state_next;
      if (arm_ok) begin
        mode_l    <= trig_mode;
        mask_l    <= trig_mask;
        value_l   <= trig_value;
        pretrig_l <= pretrig;
        wr_ptr    <= '0;
        cnt       <= '0;
      end
      if (capturing) wr_ptr <= wr_ptr + AW'(1);
      if (state == PRE) cnt <= cnt + AW'(1);
      if (trig_fire) begin
        trig_ptr <= wr_ptr;
        rem      <= rem_init;
      end else if (state == POST) begin
        rem <= rem - AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capturing) mem[wr_ptr] <= probe_in;
  end

  // Logical-to-physical translation wraps naturally in AW bits.
  assign rd_phys = trig_ptr - pretrig_l + rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_phys];
    end
  end

  assign armed     = (state == PRE) || (state == WAIT);
  assign triggered = (state == POST) || (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_la_trigger_capture.sv
// Bench for la_trigger_capture: directed and random captures against a sample-stream model.
module tb_la_trigger_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NS    = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] probe_in = '0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       trig_mode = '0;
  logic [WIDTH-1:0] trig_mask = '0;
  logic [WIDTH-1:0] trig_value = '0;
  logic [AW-1:0]    pretrig = '0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic             armed, triggered, done;

  int total = 0;
  int bad   = 0;

  logic [7:0] stream [NS];

  la_trigger_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .probe_in   (probe_in),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .pretrig    (pretrig),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic bit trig_cond(input logic [1:0] m, input logic [7:0] mk, input logic [7:0] vl,
                                   input logic [7:0] cur, input logic [7:0] prv);
    case (m)
      2'd0:    return 1'b1;
      2'd1:    return (cur & mk) == (vl & mk);
      2'd2:    return |(cur & ~prv & mk);
      default: return |((cur ^ prv) & mk);
    endcase
  endfunction

  // stream[0] is on the bus at the arm edge; stream[1..pt] fill the pre-trigger window,
  // and the trigger is searched from stream[pt+1] on with stream[i-1] as the previous sample.
  function automatic int model_trig(input logic [1:0] m, input logic [7:0] mk, input logic [7:0] vl,
                                    input int pt);
    for (int i = pt + 1; i < NS; i++)
      if (trig_cond(m, mk, vl, stream[i], stream[i-1])) return i;
    return -1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name, input logic [2:0] want);
    total++;
    if ({armed, triggered, done} !== want) begin
      bad++;
      $display("FAIL %s status {armed,triggered,done}: got %b want %b", name,
               {armed, triggered, done}, want);
    end
  endtask

  task automatic run_capture(input string name, input logic [1:0] m, input logic [7:0] mk,
                             input logic [7:0] vl, input int pt, input bit rearm);
    int t, dn, rearm_at;
    logic [2:0] want;
    t  = model_trig(m, mk, vl, pt);
    dn = (t < 0) ? NS + 100 : t + DEPTH - pt - 1;
    rearm_at = (rearm && t >= 2) ? t - 1 : -1;
    trig_mode = m; trig_mask = mk; trig_value = vl; pretrig = AW'(pt);
    for (int i = 0; i < NS; i++) begin
      probe_in = stream[i];
      arm = (i == 0) || (i == rearm_at);
      step();
      arm = 1'b0;
      // Scramble the config inputs: only the values seen at the arm edge may count.
      trig_mode = 2'($urandom); trig_mask = 8'($urandom);
      trig_value = 8'($urandom); pretrig = AW'($urandom);
      if (i >= dn) want = 3'b011;
      else if (t >= 0 && i >= t) want = 3'b010;
      else want = 3'b100;
      total++;
      if ({armed, triggered, done} !== want) begin
        bad++;
        $display("FAIL %s edge %0d status {armed,triggered,done}: got %b want %b", name, i,
                 {armed, triggered, done}, want);
      end
      if (i == dn + 1) break;
    end
    if (t >= 0 && dn + 1 < NS) begin
      for (int k = 0; k < DEPTH; k++) begin
        rd_addr = AW'(k);
        probe_in = 8'($urandom);
        step();
        total++;
        if (rd_data !== stream[t - pt + k]) begin
          bad++;
          $display("FAIL %s rd_addr %0d: got %h want %h", name, k, rd_data, stream[t - pt + k]);
        end
      end
    end else begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_status({name, " abort-after-timeout"}, 3'b000);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; arm = 1'b1; probe_in = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      step();
      check_status("reset", 3'b000);
      total++;
      if (rd_data !== 8'h00) begin
        bad++;
        $display("FAIL reset rd_data: got %h want 00", rd_data);
      end
    end
    rst = 1'b0; arm = 1'b0;
    step();
    check_status("reset arm-ignored", 3'b000);
  endtask

  task automatic test_immediate;
    for (int i = 0; i < NS; i++) stream[i] = 8'(8'h0F + i);
    run_capture("imm_pt0", 2'd0, 8'h00, 8'h00, 0, 1'b0);
  endtask

  task automatic test_level_wrap;
    for (int i = 0; i < NS; i++) stream[i] = 8'(8'h90 + i);
    run_capture("level_pt4_rearm", 2'd1, 8'hFF, 8'hA5, 4, 1'b1);
  endtask

  task automatic test_rise_full_pre;
    for (int i = 0; i < NS; i++) stream[i] = 8'(8'h60 + i);
    run_capture("rise_pt15", 2'd2, 8'h80, 8'h00, 15, 1'b0);
  endtask

  task automatic test_pre_ignored;
    for (int i = 0; i < NS; i++) begin
      stream[i] = 8'($urandom);
      if (stream[i] == 8'h03) stream[i] = 8'h13;
    end
    stream[3]  = 8'h03;
    stream[11] = 8'h03;
    run_capture("level_pre_ignored", 2'd1, 8'hFF, 8'h03, 8, 1'b0);
  endtask

  task automatic test_abort;
    for (int i = 0; i < NS; i++) stream[i] = 8'(i);
    trig_mode = 2'd0; pretrig = '0;
    arm = 1'b1; probe_in = 8'h00;
    step();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_status("abort pre-check POST", 3'b010);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_status("abort in POST", 3'b000);
    run_capture("imm_before_arm_abort", 2'd0, 8'h00, 8'h00, 3, 1'b0);
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check_status("arm+abort from DONE", 3'b000);
    arm = 1'b1;
    step();
    arm = 1'b0;
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check_status("arm+abort while armed", 3'b000);
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic [7:0] mk, vl;
    int pt, t;
    for (int r = 0; r < 6; r++) begin
      m  = 2'($urandom);
      mk = 8'(8'h01 << $urandom_range(7, 0));
      vl = 8'($urandom);
      pt = $urandom_range(DEPTH - 1, 0);
      do begin
        for (int i = 0; i < NS; i++) stream[i] = 8'($urandom);
        t = model_trig(m, mk, vl, pt);
      end while (t < 0 || t + DEPTH - pt > 200);
      run_capture($sformatf("random%0d", r), m, mk, vl, pt, r[0]);
    end
  endtask

  task automatic test_reset_mid;
    trig_mode = 2'd0; pretrig = '0; arm = 1'b1;
    step();
    arm = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_status("reset mid-capture", 3'b000);
    total++;
    if (rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset mid-capture rd_data: got %h want 00", rd_data);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_immediate();
    test_level_wrap();
    test_rise_full_pre();
    test_pre_ignored();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
